// File: rtl/mem_access_stage.sv
// Memory access stage: runs the data-memory req/ack handshake, stalls the
// upstream register while busy, and registers the writeback bundle.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] pc,
    input  logic [31:0] instr_in,
    input  logic [31:0] address_in,
    input  logic [31:0] data_in,
    input  logic        mem_read_write_in,
    input  logic        mem_enable_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_instr,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_exc
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;

    assign stall_out = (state == WAIT);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pc_q       <= '0;
            instr_q    <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_pc      <= '0;
            wb_instr   <= '0;
            wb_data    <= '0;
            wb_exc     <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!mem_enable_in) begin
                        wb_valid <= 1'b1;
                        wb_pc    <= pc;
                        wb_instr <= instr_in;
                        wb_data  <= address_in;
                        wb_exc   <= 2'b00;
                    end else if (address_in[1:0] != 2'b00) begin
                        wb_valid <= 1'b1;
                        wb_pc    <= pc;
                        wb_instr <= instr_in;
                        wb_data  <= address_in;
                        wb_exc   <= 2'b01;
                    end else begin
                        pc_q       <= pc;
                        instr_q    <= instr_in;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_read_write_in;
                        dmem_addr  <= address_in;
                        dmem_wdata <= data_in;
                        cnt        <= '0;
                        wb_valid   <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // ack takes priority over an expiring timeout
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_pc    <= pc_q;
                        wb_instr <= instr_q;
                        wb_data  <= dmem_we ? dmem_addr : dmem_rdata;
                        wb_exc   <= 2'b00;
                        state    <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_pc    <= pc_q;
                        wb_instr <= instr_q;
                        wb_data  <= dmem_addr;
                        wb_exc   <= 2'b10;
                        state    <= IDLE;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        wb_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] pc, instr_in, address_in, data_in;
    logic        mem_read_write_in, mem_enable_in;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_instr, wb_data;
    logic [1:0]  wb_exc;

    int n_chk  = 0;
    int n_fail = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .pc(pc), .instr_in(instr_in),
        .address_in(address_in), .data_in(data_in),
        .mem_read_write_in(mem_read_write_in), .mem_enable_in(mem_enable_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_instr(wb_instr), .wb_data(wb_data), .wb_exc(wb_exc)
    );

    always #5 clock = ~clock;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // transaction-level model: one outstanding access with its age in cycles
    bit          live = 0;
    bit          busy = 0;
    int          age;
    logic [31:0] t_pc, t_instr, t_addr, t_wdata;
    logic        t_we;
    logic        e_req, e_we, e_wbv;
    logic [31:0] e_addr, e_wdata, e_pc, e_instr, e_data;
    logic [1:0]  e_exc;

    task automatic retire(logic [31:0] p, logic [31:0] i,
                          logic [31:0] d, logic [1:0] x);
        e_wbv = 1; e_pc = p; e_instr = i; e_data = d; e_exc = x;
    endtask

    task automatic model_edge();
        live = 1;
        if (!reset_n) begin
            busy = 0;
            {e_req, e_we, e_wbv, e_exc} = '0;
            {e_addr, e_wdata, e_pc, e_instr, e_data} = '0;
        end else if (busy) begin
            age++;
            e_wbv = 0;
            if (dmem_ack) begin
                busy = 0; e_req = 0;
                retire(t_pc, t_instr, t_we ? t_addr : dmem_rdata, 2'b00);
            end else if (age == TO) begin
                busy = 0; e_req = 0;
                retire(t_pc, t_instr, t_addr, 2'b10);
            end
        end else if (!mem_enable_in) begin
            retire(pc, instr_in, address_in, 2'b00);
        end else if (address_in % 4 != 0) begin
            retire(pc, instr_in, address_in, 2'b01);
        end else begin
            busy = 1; age = 0;
            t_pc = pc; t_instr = instr_in; t_addr = address_in;
            t_wdata = data_in; t_we = mem_read_write_in;
            e_req = 1; e_we = t_we; e_addr = t_addr; e_wdata = t_wdata;
            e_wbv = 0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    always @(negedge clock) begin
        if (live) begin
            chk("stall", {31'b0, stall_out}, {31'b0, busy});
            chk("req", {31'b0, dmem_req}, {31'b0, e_req});
            chk("we", {31'b0, dmem_we}, {31'b0, e_we});
            chk("addr", dmem_addr, e_addr);
            chk("wdata", dmem_wdata, e_wdata);
            chk("wb_valid", {31'b0, wb_valid}, {31'b0, e_wbv});
            chk("wb_pc", wb_pc, e_pc);
            chk("wb_instr", wb_instr, e_instr);
            chk("wb_data", wb_data, e_data);
            chk("wb_exc", {30'b0, wb_exc}, {30'b0, e_exc});
        end
    end

    // run lengths of dmem_req and stall_out
    int req_run = 0, last_req = 0, st_run = 0, last_st = 0;
    always @(negedge clock) begin
        if (dmem_req === 1'b1) req_run++;
        else if (req_run != 0) begin last_req = req_run; req_run = 0; end
        if (stall_out === 1'b1) st_run++;
        else if (st_run != 0) begin last_st = st_run; st_run = 0; end
    end

    task automatic issue(logic [31:0] p, logic [31:0] a,
                         logic [31:0] d, logic rw);
        pc = p; instr_in = p ^ 32'h5A5A_0000; address_in = a;
        data_in = d; mem_read_write_in = rw; mem_enable_in = 1;
        step();
        mem_enable_in = 0;
    endtask

    task automatic wait_ack(int n, logic [31:0] rd);
        for (int i = 0; i < n - 1; i++) begin
            dmem_ack = 0; step();
        end
        dmem_ack = 1; dmem_rdata = rd;
        step();
        dmem_ack = 0;
        @(negedge clock); #1;
    endtask

    initial begin
        reset_n = 0; dmem_ack = 1;
        pc = $urandom; instr_in = $urandom; address_in = $urandom;
        data_in = $urandom; dmem_rdata = $urandom;
        mem_read_write_in = 1'($urandom); mem_enable_in = 1;
        step(); step();
        chk("rst_req", {31'b0, dmem_req}, 0);
        chk("rst_wbv", {31'b0, wb_valid}, 0);
        chk("rst_stall", {31'b0, stall_out}, 0);
        chk("rst_data", wb_data, 0);

        dmem_ack = 0; mem_enable_in = 0; address_in = 0; pc = 0;
        reset_n = 1;
        step();

        issue(32'h1000, 32'h100, 32'h0, 1'b0);
        chk("rd_we", {31'b0, dmem_we}, 0);
        chk("rd_addr", dmem_addr, 32'h100);
        wait_ack(3, 32'hDEADBEEF);
        chk("rd_data", wb_data, 32'hDEADBEEF);
        chk("rd_exc", {30'b0, wb_exc}, 0);
        chk("rd_pc", wb_pc, 32'h1000);
        chk("rd_reqlen", last_req, 3);
        chk("rd_stlen", last_st, 3);

        issue(32'h1004, 32'h204, 32'h12345678, 1'b1);
        chk("wr_we", {31'b0, dmem_we}, 1);
        chk("wr_wdata", dmem_wdata, 32'h12345678);
        wait_ack(1, 32'hFFFF0000);
        chk("wr_data", wb_data, 32'h204);
        chk("wr_exc", {30'b0, wb_exc}, 0);
        chk("wr_stlen", last_st, 1);

        mem_enable_in = 1; mem_read_write_in = 0; address_in = 32'h102;
        step();
        chk("mis_v", {31'b0, wb_valid}, 1);
        chk("mis_exc", {30'b0, wb_exc}, 1);
        chk("mis_data", wb_data, 32'h102);
        mem_enable_in = 0;
        for (int k = 1; k <= 3; k++) begin
            address_in = k;
            step();
            chk("pt_v", {31'b0, wb_valid}, 1);
            chk("pt_exc", {30'b0, wb_exc}, 0);
            chk("pt_data", wb_data, k);
            chk("pt_req", {31'b0, dmem_req | stall_out}, 0);
        end
        address_in = 0;

        issue(32'h2000, 32'h300, 32'h0, 1'b0);
        for (int i = 0; i < TO; i++) step();
        @(negedge clock); #1;
        chk("to_v", {31'b0, wb_valid}, 1);
        chk("to_exc", {30'b0, wb_exc}, 2);
        chk("to_data", wb_data, 32'h300);
        chk("to_reqlen", last_req, TO);

        issue(32'h2004, 32'h304, 32'h0, 1'b0);
        wait_ack(TO, 32'hCAFEF00D);
        chk("ack16_exc", {30'b0, wb_exc}, 0);
        chk("ack16_data", wb_data, 32'hCAFEF00D);
        chk("ack16_len", last_req, TO);

        issue(32'h3000, 32'h400, 32'h0, 1'b0);
        step();
        reset_n = 0;
        step();
        chk("mr_req", {31'b0, dmem_req}, 0);
        chk("mr_wbv", {31'b0, wb_valid}, 0);
        reset_n = 1; dmem_ack = 1; dmem_rdata = 32'hBAD0BAD0;
        pc = 32'h3004; instr_in = 32'h77; address_in = 32'h408;
        mem_enable_in = 1; mem_read_write_in = 0;
        step();
        mem_enable_in = 0;
        chk("late_req", {31'b0, dmem_req}, 1);
        chk("late_wbv", {31'b0, wb_valid}, 0);
        wait_ack(2, 32'h0BADF00D);
        chk("post_data", wb_data, 32'h0BADF00D);
        chk("post_pc", wb_pc, 32'h3004);
        chk("post_exc", {30'b0, wb_exc}, 0);

        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
